// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC decimation-rate controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    APPLY    = 2'd2,
    SETTLE   = 2'd3
  } cic_ctrl_state_t;

  // Arguments are widened to 64 bits so any rate word width can be checked.
  function automatic logic rate_legal(input logic [63:0] rate,
                                      input logic [63:0] rate_min,
                                      input logic [63:0] rate_max);
    return (rate >= rate_min) && (rate <= rate_max);
  endfunction

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// Signal bundle between the rate controller and its surroundings: config bus, CIC rate port,
// CIC output stream in, gated stream out and status.
interface cic_rate_ctrl_if #(
  parameter int RATE_DW = 32,
  parameter int OUT_DW  = 32
);
  logic [RATE_DW-1:0] s_axis_cfg_tdata;
  logic               s_axis_cfg_tvalid;
  logic               s_axis_cfg_tready;
  logic [RATE_DW-1:0] m_axis_rate_tdata;
  logic               m_axis_rate_tvalid;
  logic [OUT_DW-1:0]  s_axis_cic_tdata;
  logic               s_axis_cic_tvalid;
  logic [OUT_DW-1:0]  m_axis_out_tdata;
  logic               m_axis_out_tvalid;
  logic [RATE_DW-1:0] cur_rate;
  logic               busy;
  logic               cfg_err;

  // Controller side.
  modport master (
    input  s_axis_cfg_tdata, s_axis_cfg_tvalid, s_axis_cic_tdata, s_axis_cic_tvalid,
    output s_axis_cfg_tready, m_axis_rate_tdata, m_axis_rate_tvalid,
           m_axis_out_tdata, m_axis_out_tvalid, cur_rate, busy, cfg_err
  );

  // Environment side: software, CIC filter and downstream consumer.
  modport slave (
    output s_axis_cfg_tdata, s_axis_cfg_tvalid, s_axis_cic_tdata, s_axis_cic_tvalid,
    input  s_axis_cfg_tready, m_axis_rate_tdata, m_axis_rate_tvalid,
           m_axis_out_tdata, m_axis_out_tvalid, cur_rate, busy, cfg_err
  );
endinterface

// File: rtl/cic_sat_counter.sv
// Clear/enable up-counter that sticks at its all-ones value instead of wrapping.
module cic_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time decimation-rate controller: validates rate requests, applies them to the CIC on an
// output-sample boundary and blanks the filter's settling transient.
module cic_rate_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int RATE_DW        = 32,
  parameter int OUT_DW         = 32,
  parameter int CIC_R          = 10,
  parameter int RATE_MIN       = 2,
  parameter int SETTLE_SAMPLES = 7,
  parameter int TIMEOUT        = 1024
) (
  input  logic            clk,
  input  logic            reset,
  cic_rate_ctrl_if.master bus
);
  localparam int CNT_MAX = (TIMEOUT > SETTLE_SAMPLES) ? TIMEOUT : SETTLE_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_IDX  = 0;
  localparam int ST_IDX  = 1;
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_CNT  = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [RATE_DW-1:0] RATE_RST    = RATE_DW'(CIC_R);

  cic_ctrl_state_t    state_reg, state_next;
  logic [RATE_DW-1:0] pend_rate_reg, cur_rate_reg;
  logic               cfg_err_reg;
  logic [OUT_DW-1:0]  out_tdata_reg;
  logic               out_tvalid_reg;

  logic [1:0]         cnt_clr, cnt_en;
  logic [CNT_W-1:0]   cnt_val [2];
  logic               cfg_ready, cfg_fire, req_legal, req_take, drop, rate_strobe;

  assign cfg_ready = (state_reg == IDLE) && !reset;
  assign cfg_fire  = bus.s_axis_cfg_tvalid && cfg_ready;
  assign req_legal = rate_legal(64'(bus.s_axis_cfg_tdata), 64'(RATE_MIN), 64'(CIC_R));
  assign req_take  = cfg_fire && req_legal && (bus.s_axis_cfg_tdata != cur_rate_reg);

  // Index 0 times out the boundary wait, index 1 counts dropped settle samples.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      cic_sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr[gi]),
        .en    (cnt_en[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rate_strobe = 1'b0;
    drop        = 1'b0;
    cnt_clr     = 2'b11;
    cnt_en      = 2'b00;
    case (state_reg)
      IDLE: begin
        if (req_take) state_next = WAIT_BND;
      end
      WAIT_BND: begin
        cnt_clr[TO_IDX] = 1'b0;
        cnt_en[TO_IDX]  = 1'b1;
        if (bus.s_axis_cic_tvalid || (cnt_val[TO_IDX] == TO_LAST)) state_next = APPLY;
      end
      APPLY: begin
        // A sample arriving with the strobe is already at the new rate: first drop.
        rate_strobe     = 1'b1;
        drop            = (SETTLE_SAMPLES != 0);
        cnt_clr[ST_IDX] = 1'b0;
        cnt_en[ST_IDX]  = bus.s_axis_cic_tvalid;
        state_next      = (SETTLE_SAMPLES == 0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        drop            = 1'b1;
        cnt_clr[ST_IDX] = 1'b0;
        cnt_en[ST_IDX]  = bus.s_axis_cic_tvalid;
        if ((cnt_val[ST_IDX] >= SETTLE_CNT) ||
            (bus.s_axis_cic_tvalid && (cnt_val[ST_IDX] == SETTLE_LAST))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_rate_reg  <= RATE_RST;
      cur_rate_reg   <= RATE_RST;
      cfg_err_reg    <= 1'b0;
      out_tdata_reg  <= '0;
      out_tvalid_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_fire && !req_legal;
      if (req_take) pend_rate_reg <= bus.s_axis_cfg_tdata;
      if (rate_strobe) cur_rate_reg <= pend_rate_reg;
      out_tvalid_reg <= bus.s_axis_cic_tvalid && !drop;
      if (bus.s_axis_cic_tvalid && !drop) out_tdata_reg <= bus.s_axis_cic_tdata;
    end
  end

  assign bus.s_axis_cfg_tready  = cfg_ready;
  assign bus.m_axis_rate_tvalid = rate_strobe;
  assign bus.m_axis_rate_tdata  = rate_strobe ? pend_rate_reg : cur_rate_reg;
  assign bus.m_axis_out_tdata   = out_tdata_reg;
  assign bus.m_axis_out_tvalid  = out_tvalid_reg;
  assign bus.cur_rate           = cur_rate_reg;
  assign bus.busy               = (state_reg != IDLE);
  assign bus.cfg_err            = cfg_err_reg;
endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl: randomized CIC streams and rate requests checked
// against an event-level model of when the rate applies and which samples get blanked.
module tb_cic_rate_ctrl;
  localparam int RATE_DW = 32, OUT_DW = 32, CIC_R = 10, RATE_MIN = 2;
  localparam int SETTLE_SAMPLES = 7, TIMEOUT = 1024, MAXN = 1400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cic_rate_ctrl_if #(.RATE_DW(RATE_DW), .OUT_DW(OUT_DW)) bus ();

  cic_rate_ctrl #(
    .RATE_DW(RATE_DW), .OUT_DW(OUT_DW), .CIC_R(CIC_R), .RATE_MIN(RATE_MIN),
    .SETTLE_SAMPLES(SETTLE_SAMPLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  int model_cur = CIC_R;

  bit          vld [MAXN];
  logic [31:0] dat [MAXN];
  bit          dropped [MAXN];
  bit          obs_busy [MAXN+1];
  int          obs_strobe_cyc[$];
  logic [31:0] obs_strobe_dat[$];
  int          obs_out_cyc[$];
  logic [31:0] obs_out_dat[$];
  int          obs_err_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One request at req_at over n cycles of CIC traffic; optional one-cycle reset after the
  // rst_drops-th blanked sample.
  task automatic scenario(input string name, input int req, input int req_at, input int n,
                          input int period, input int quiet, input int rst_drops);
    int apply, busy_end, rst_cyc, cnt, mism, exp_cur, exp_strobes, m;
    bit illegal, change, expb;
    int drop_cyc[$];
    int exp_out_cyc[$];
    logic [31:0] exp_out_dat[$];

    for (int k = 0; k < n; k++) begin
      vld[k] = (k >= quiet) &&
               ((period > 0) ? (k % period == period - 1) : ($urandom_range(0, 2) == 0));
      dat[k] = $urandom;
      dropped[k] = 1'b0;
    end

    illegal  = (req < RATE_MIN) || (req > CIC_R);
    change   = !illegal && (req != model_cur);
    apply    = -1;
    busy_end = -1;
    rst_cyc  = -1;
    if (change) begin
      apply = req_at + TIMEOUT + 1;
      for (int c = req_at + 1; c <= req_at + TIMEOUT; c++) begin
        if (c < n && vld[c]) begin
          apply = c + 1;
          break;
        end
      end
      busy_end = n;
      cnt = 0;
      for (int c = apply; c < n && cnt < SETTLE_SAMPLES; c++) begin
        if (vld[c]) begin
          dropped[c] = 1'b1;
          drop_cyc.push_back(c);
          cnt++;
          if (cnt == SETTLE_SAMPLES) busy_end = c;
        end
      end
      if (rst_drops > 0 && drop_cyc.size() >= rst_drops) rst_cyc = drop_cyc[rst_drops-1] + 1;
    end

    for (int c = 0; c < n; c++) begin
      if (!vld[c] || c == rst_cyc) continue;
      if (dropped[c] && (rst_cyc < 0 || c < rst_cyc)) continue;
      exp_out_cyc.push_back(c + 1);
      exp_out_dat.push_back(dat[c]);
    end

    obs_strobe_cyc.delete(); obs_strobe_dat.delete();
    obs_out_cyc.delete();    obs_out_dat.delete();
    obs_err_cyc.delete();
    for (int k = 0; k < n; k++) begin
      bus.s_axis_cfg_tvalid = (k == req_at);
      bus.s_axis_cfg_tdata  = 32'(req);
      bus.s_axis_cic_tvalid = vld[k];
      bus.s_axis_cic_tdata  = dat[k];
      reset = (k == rst_cyc);
      if (k == req_at) begin
        #1;
        check({name, " tready"}, 64'(bus.s_axis_cfg_tready), 64'd1);
      end
      @(posedge clk);
      #1;
      if (bus.m_axis_rate_tvalid) begin
        obs_strobe_cyc.push_back(k + 1);
        obs_strobe_dat.push_back(bus.m_axis_rate_tdata);
      end
      if (bus.m_axis_out_tvalid) begin
        obs_out_cyc.push_back(k + 1);
        obs_out_dat.push_back(bus.m_axis_out_tdata);
      end
      if (bus.cfg_err) obs_err_cyc.push_back(k + 1);
      obs_busy[k+1] = bus.busy;
    end
    bus.s_axis_cfg_tvalid = 1'b0;
    bus.s_axis_cic_tvalid = 1'b0;
    reset = 1'b0;

    exp_strobes = (change && apply <= n && (rst_cyc < 0 || apply <= rst_cyc)) ? 1 : 0;
    check({name, " strobe count"}, 64'(obs_strobe_cyc.size()), 64'(exp_strobes));
    if (exp_strobes == 1 && obs_strobe_cyc.size() == 1) begin
      check({name, " strobe cycle"}, 64'(obs_strobe_cyc[0]), 64'(apply));
      check({name, " strobe rate"}, 64'(obs_strobe_dat[0]), 64'(req));
    end

    check({name, " out count"}, 64'(obs_out_cyc.size()), 64'(exp_out_cyc.size()));
    m = (obs_out_cyc.size() < exp_out_cyc.size()) ? obs_out_cyc.size() : exp_out_cyc.size();
    for (int i = 0; i < m; i++) begin
      check({name, " out cycle"}, 64'(obs_out_cyc[i]), 64'(exp_out_cyc[i]));
      check({name, " out data"}, 64'(obs_out_dat[i]), 64'(exp_out_dat[i]));
    end

    check({name, " cfg_err count"}, 64'(obs_err_cyc.size()), 64'(illegal ? 1 : 0));
    if (illegal && obs_err_cyc.size() > 0)
      check({name, " cfg_err cycle"}, 64'(obs_err_cyc[0]), 64'(req_at + 1));

    mism = 0;
    for (int k = 1; k <= n; k++) begin
      expb = change && (k > req_at) && (k <= busy_end) && (rst_cyc < 0 || k <= rst_cyc);
      if (obs_busy[k] != expb) mism++;
    end
    check({name, " busy trace errors"}, 64'(mism), 64'd0);

    exp_cur = (rst_cyc >= 0) ? CIC_R : (change ? req : model_cur);
    check({name, " cur_rate"}, 64'(bus.cur_rate), 64'(exp_cur));
    $display("[%s] req=%0d apply=%0d reset_at=%0d strobes=%0d outs=%0d cur_rate=%0d",
             name, req, apply, rst_cyc, obs_strobe_cyc.size(), obs_out_cyc.size(), bus.cur_rate);
    model_cur = exp_cur;
  endtask

  initial begin
    int r;
    bus.s_axis_cfg_tvalid = 1'b0;
    bus.s_axis_cfg_tdata  = '0;
    bus.s_axis_cic_tvalid = 1'b0;
    bus.s_axis_cic_tdata  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("tready in reset", 64'(bus.s_axis_cfg_tready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst cur_rate", 64'(bus.cur_rate), 64'(CIC_R));
    check("rst tready", 64'(bus.s_axis_cfg_tready), 64'd1);
    check("rst rate_tvalid", 64'(bus.m_axis_rate_tvalid), 64'd0);
    check("rst rate_tdata", 64'(bus.m_axis_rate_tdata), 64'(CIC_R));
    check("rst out_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    check("rst out_tdata", 64'(bus.m_axis_out_tdata), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst cfg_err", 64'(bus.cfg_err), 64'd0);

    scenario("bad_1", 1, 2, 20, 0, 0, 0);
    scenario("bad_11", 11, 2, 20, 0, 0, 0);
    scenario("bad_max", -1, 2, 20, 0, 0, 0);
    scenario("same_10", 10, 2, 20, 0, 0, 0);
    scenario("rate_5", 5, 3, 120, 10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      r = ($urandom_range(0, 4) == 0) ? $urandom_range(11, 1000) : $urandom_range(2, 10);
      scenario("random", r, $urandom_range(1, 5), 150, 0, 0, 0);
    end
    r = (model_cur == 7) ? 8 : 7;
    scenario("timeout", r, 2, 1200, 3, 1100, 0);
    r = (model_cur == 4) ? 6 : 4;
    scenario("reset_settle", r, 3, 150, 0, 0, 3);
    scenario("after_reset", 3, 2, 150, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cic_rate_ctrl.md
# cic_rate_ctrl

Run-time decimation-rate controller for the variable-rate CIC decimator (`cic_d`, VARIABLE_RATE=1). It accepts rate requests from software, validates them, and applies each rate to the filter only on an output-sample boundary. After a change it discards the filter's transient output samples. The block sits between the configuration bus and the CIC rate port, and gates the CIC output stream on its way downstream.

## Interface
Parameters:
- RATE_DW, 32, rate word width (matches `cic_d`)
- OUT_DW, 32, CIC output sample width
- CIC_R, 10, maximum/reset decimation ratio (matches `cic_d`)
- RATE_MIN, 2, smallest legal ratio
- SETTLE_SAMPLES, 7, CIC output samples discarded after a change (CIC_N·CIC_M)
- TIMEOUT, 1024, clk cycles to wait for a boundary before forcing the change

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; must also reset the attached `cic_d`
- s_axis_cfg_tdata  in  RATE_DW  requested ratio
- s_axis_cfg_tvalid  in  1  request valid
- s_axis_cfg_tready  out  1  request accepted when high with tvalid
- m_axis_rate_tdata  out  RATE_DW  ratio to CIC `s_axis_rate_tdata`
- m_axis_rate_tvalid  out  1  one-cycle apply strobe to CIC
- s_axis_cic_tdata  in  OUT_DW  CIC output sample
- s_axis_cic_tvalid  in  1  CIC output valid (no backpressure)
- m_axis_out_tdata  out  OUT_DW  gated sample downstream
- m_axis_out_tvalid  out  1  gated valid
- cur_rate  out  RATE_DW  ratio currently applied
- busy  out  1  change in progress
- cfg_err  out  1  one-cycle pulse, request rejected

## Operation
- States: IDLE, WAIT_BND, APPLY, SETTLE.
- IDLE:
  - tready=1.
  - On handshake with rate < RATE_MIN or > CIC_R: pulse cfg_err next cycle, stay IDLE.
  - On handshake with rate == cur_rate: accept as a no-op. No strobe, no blanking, stay IDLE.
  - On any other valid rate: latch it into pend_rate and go to WAIT_BND.
- WAIT_BND:
  - tready=0. A cycle counter starts at 0.
  - On s_axis_cic_tvalid, go to APPLY. That sample is still forwarded; it belongs to the old rate.
  - On counter == TIMEOUT-1, go to APPLY, covering a stalled input.
- APPLY (one cycle):
  - m_axis_rate_tvalid=1, m_axis_rate_tdata=pend_rate; cur_rate<=pend_rate.
  - Clear the sample counter. Go to SETTLE, or to IDLE if SETTLE_SAMPLES==0.
- SETTLE:
  - Each s_axis_cic_tvalid increments the counter and is dropped (m_axis_out_tvalid held 0).
  - After the SETTLE_SAMPLES-th dropped sample, go to IDLE. The next sample is forwarded.
- busy=1 in every state other than IDLE.
- Forwarding outside SETTLE: m_axis_out_tdata<=s_axis_cic_tdata and m_axis_out_tvalid<=s_axis_cic_tvalid, registered. Data holds its last value when valid is low.
- Counters are sized $clog2(max(TIMEOUT,SETTLE_SAMPLES)+1) and saturate; they never wrap.

## Timing
- Reset values:
  - s_axis_cfg_tready=0 during reset, 1 from the first cycle after.
  - m_axis_rate_tvalid=0, m_axis_rate_tdata=CIC_R, cur_rate=CIC_R.
  - m_axis_out_tvalid=0, m_axis_out_tdata=0, busy=0, cfg_err=0. State is IDLE.
- Request accepted in cycle t → busy=1 in t+1.
- Boundary sample in cycle b → rate strobe in b+1 (APPLY).
- Forward path latency is 1 cycle.
- s_axis_cic_tvalid in the APPLY cycle counts as the first settle sample.
- s_axis_cfg_tvalid held during busy is not accepted; it is accepted in the first IDLE cycle.
- Reset mid-change aborts and returns to reset values. pend_rate is lost and no strobe is issued.
- m_axis_rate_tvalid is never high for more than one consecutive cycle.

## Structure
- Package `cic_ctrl_pkg`: state enum `cic_ctrl_state_t`, and function `rate_legal(rate, min, max)`.
- One sub-module, `cic_sat_counter`: a clear/enable saturating counter, instantiated twice (timeout and settle).
- Everything else lives in `cic_rate_ctrl`.

## Test plan
- Reset release: cur_rate=10, tready=1 at cycle 1, no strobe, outputs 0.
- Request 5 with CIC valid every 10 cycles:
  - one strobe carrying 5, the cycle after the next CIC valid;
  - next 7 CIC samples dropped, 8th forwarded;
  - busy low after the 7th drop.
- Request 1 and request 11: cfg_err pulses once each, cur_rate stays 10, no strobe.
- Request 10 while at 10: accepted, no strobe, busy stays 0.
- CIC valid held low: strobe fires exactly TIMEOUT=1024 cycles after entering WAIT_BND.
- Reset asserted during SETTLE after 3 drops: state IDLE, cur_rate=10, the next CIC sample after reset release is forwarded.
